// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, access width/type codes,
// requester ownership and the IO address window decode.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MW_BYTE = 2'd0,
        MW_HALF = 2'd1,
        MW_WORD = 2'd2
    } mem_width_e;

    typedef enum logic {
        MT_LOAD  = 1'b0,
        MT_STORE = 1'b1
    } mem_type_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSB = 1'b1
    } owner_e;

    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // Width code 3 is unused by the LSB and treated as a word.
    function automatic logic [2:0] width_bytes(input logic [1:0] width);
        case (width)
            MW_BYTE: return 3'd1;
            MW_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: owns the byte counter, latched access, address/data muxing and
// little-endian assembly of read bytes for the memory port arbiter.
module mem_byte_seq
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_abort,
    input  logic        i_start,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_nbytes,
    input  state_e      i_state,
    input  logic        i_hold,
    input  logic [7:0]  i_mem_din,
    output logic [31:0] o_mem_a,
    output logic [7:0]  o_mem_dout,
    output logic        o_rd_last,
    output logic        o_wr_last,
    output logic        o_io_target,
    output logic [31:0] o_rd_word
);

    logic [2:0]  r_cnt;
    logic [2:0]  r_nbytes;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] w_addr;
    logic [31:0] w_word;

    assign w_addr      = r_base + {29'd0, r_cnt};
    assign o_rd_last   = (i_state == ST_RD) && (r_cnt == r_nbytes);
    assign o_wr_last   = (i_state == ST_WR) && !i_hold && (r_cnt == r_nbytes - 3'd1);
    assign o_io_target = (r_base[17:16] == IO_ADDR_HI);
    assign o_rd_word   = w_word;

    assign o_mem_a = (((i_state == ST_RD) && (r_cnt < r_nbytes)) || (i_state == ST_WR))
                     ? w_addr : 32'd0;
    assign o_mem_dout = (i_state == ST_WR) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;

    // mem_din carries the byte addressed in the previous cycle, i.e. byte cnt-1.
    always_comb begin
        w_word = r_word;
        for (int i = 0; i < 4; i++) begin
            if (r_cnt == 3'(i + 1)) w_word[8*i +: 8] = i_mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 3'd0;
            r_nbytes <= 3'd0;
            r_base   <= 32'd0;
            r_wdata  <= 32'd0;
            r_word   <= 32'd0;
        end else if (i_abort) begin
            r_cnt  <= 3'd0;
            r_word <= 32'd0;
        end else if (i_en) begin
            if (i_start) begin
                r_cnt    <= 3'd0;
                r_base   <= i_addr;
                r_wdata  <= i_wdata;
                r_nbytes <= i_nbytes;
                r_word   <= 32'd0;
            end else if (i_state == ST_RD) begin
                r_word <= w_word;
                r_cnt  <= o_rd_last ? 3'd0 : r_cnt + 3'd1;
            end else if ((i_state == ST_WR) && !i_hold) begin
                r_cnt <= o_wr_last ? 3'd0 : r_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the byte-wide RAM/IO port between instruction fetch and the load/store buffer.
// Optional IF anti-starvation aging is enabled by defining ARB_AGING_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int IF_STARVE_MAX = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_wrong,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_type,
    input  logic [1:0]  lsb_width,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);

    state_e      r_state;
    state_e      w_next_state;
    owner_e      r_owner;
    logic        r_if_done;
    logic        r_lsb_done;
    logic [31:0] r_if_data;
    logic [31:0] r_lsb_rdata;

    logic        w_grant_if;
    logic        w_grant_lsb;
    logic        w_finish;
    logic        w_abort;
    logic        w_hold;
    logic        w_age_force;
    logic        w_rd_last;
    logic        w_wr_last;
    logic        w_io_target;
    logic [31:0] w_rd_word;
    logic [31:0] w_start_addr;
    logic [2:0]  w_start_nbytes;

    assign w_abort        = jump_wrong && (r_state == ST_RD);
    assign w_hold         = w_io_target && io_buffer_full;
    assign w_start_addr   = w_grant_lsb ? lsb_addr : if_addr;
    assign w_start_nbytes = w_grant_lsb ? width_bytes(lsb_width) : 3'd4;

    assign mem_wr    = (r_state == ST_WR) && rdy && !w_hold;
    assign if_done   = r_if_done;
    assign lsb_done  = r_lsb_done;
    assign if_data   = r_if_data;
    assign lsb_rdata = r_lsb_rdata;

    mem_byte_seq u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_en        (rdy),
        .i_abort     (w_abort),
        .i_start     (w_grant_if || w_grant_lsb),
        .i_addr      (w_start_addr),
        .i_wdata     (lsb_wdata),
        .i_nbytes    (w_start_nbytes),
        .i_state     (r_state),
        .i_hold      (w_hold),
        .i_mem_din   (mem_din),
        .o_mem_a     (mem_a),
        .o_mem_dout  (mem_dout),
        .o_rd_last   (w_rd_last),
        .o_wr_last   (w_wr_last),
        .o_io_target (w_io_target),
        .o_rd_word   (w_rd_word)
    );

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_lsb  = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A done pulse means the finishing requester may still hold req high.
                if (rdy && !r_if_done && !r_lsb_done) begin
                    if (jump_wrong)                 w_grant_lsb = lsb_req && (lsb_type == MT_STORE);
                    else if (w_age_force && if_req) w_grant_if  = 1'b1;
                    else if (lsb_req)               w_grant_lsb = 1'b1;
                    else if (if_req)                w_grant_if  = 1'b1;
                    if (w_grant_lsb)     w_next_state = (lsb_type == MT_STORE) ? ST_WR : ST_RD;
                    else if (w_grant_if) w_next_state = ST_RD;
                end
            end
            ST_RD: begin
                if (jump_wrong) begin
                    w_next_state = ST_IDLE;
                end else if (rdy && w_rd_last) begin
                    w_next_state = ST_IDLE;
                    w_finish     = 1'b1;
                end
            end
            ST_WR: begin
                if (rdy && w_wr_last) begin
                    w_next_state = ST_IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_if_done   <= 1'b0;
            r_lsb_done  <= 1'b0;
            r_if_data   <= 32'd0;
            r_lsb_rdata <= 32'd0;
        end else begin
            if (rdy || w_abort) r_state <= w_next_state;
            if (rdy) begin
                r_if_done  <= w_finish && (r_owner == OWN_IF);
                r_lsb_done <= w_finish && (r_owner == OWN_LSB);
                if (w_grant_if || w_grant_lsb) r_owner <= w_grant_lsb ? OWN_LSB : OWN_IF;
                if (w_finish && (r_state == ST_RD)) begin
                    if (r_owner == OWN_IF) r_if_data   <= w_rd_word;
                    else                   r_lsb_rdata <= w_rd_word;
                end
            end
        end
    end

`ifdef ARB_AGING_EN
    localparam logic [7:0] STARVE_LIM = 8'(IF_STARVE_MAX);
    logic [7:0] r_starve;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 8'd0;
        end else if (w_grant_if) begin
            r_starve <= 8'd0;
        end else if (w_grant_lsb && if_req && (r_starve < STARVE_LIM)) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    assign w_age_force = (r_starve >= STARVE_LIM);
`else
    localparam int unused_if_starve_max = IF_STARVE_MAX;
    assign w_age_force = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a byte-wide RAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_wrong, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_type, lsb_done;
    logic [1:0]  lsb_width;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ram [0:262143];

    mem_port_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_type(lsb_type), .lsb_width(lsb_width),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done),
        .lsb_rdata(lsb_rdata)
    );

    always #5 clk = ~clk;

    // RAM returns the byte addressed one active cycle earlier; it pauses with the rest of the system.
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[17:0]];
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n_done;
        logic [5:0] order;
        logic [5:0] exp_order;

        rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_type = 1'b0; lsb_width = 2'd0; lsb_addr = '0; lsb_wdata = '0;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h00100] = 8'h13;
        {ram[18'h00003], ram[18'h00002], ram[18'h00001], ram[18'h00000]} = 32'h0010_0093;
        {ram[18'h00203], ram[18'h00202], ram[18'h00201], ram[18'h00200]} = 32'h1234_5678;
        {ram[18'h00703], ram[18'h00702], ram[18'h00701], ram[18'h00700]} = 32'h4433_2211;
        {ram[18'h00803], ram[18'h00802], ram[18'h00801], ram[18'h00800]} = 32'hDEAD_BEEF;
        ram[18'h00900] = 8'hC3;
        ram[18'h30002] = 8'h5A;

        // Reset state
        repeat (3) cycle();
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_wr_dout", {mem_wr, mem_dout}, 9'd0);
        check("rst_dones", {if_done, lsb_done}, 2'b00);
        check("rst_data", if_data | lsb_rdata, 32'd0);
        rst = 1'b0;

        // Fetch only: word at 0x100, done 6 cycles after the request is seen
        cycle(); if_req = 1'b1; if_addr = 32'h100; #1;
        check("t1_idle_a", mem_a, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("t1_a%0d", k), mem_a, 32'h100 + k);
        end
        cycle(); check("t1_done_early", if_done, 1'b0);
        cycle(); check("t1_done", if_done, 1'b1); check("t1_data", if_data, 32'h0000_0013);
        cycle(); if_req = 1'b0; #1; check("t1_done_pulse", if_done, 1'b0);
        check("t1_no_regrant", mem_a, 32'd0);

        // Both requesters together: LSB word load first, then IF after the done cycle
        cycle();
        lsb_req = 1'b1; lsb_type = 1'b0; lsb_width = 2'd2; lsb_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h0; #1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("t2_lsb_a%0d", k), mem_a, 32'h200 + k);
        end
        cycle(); check("t2_lsb_done_early", lsb_done, 1'b0);
        cycle(); check("t2_lsb_done", lsb_done, 1'b1); check("t2_rdata", lsb_rdata, 32'h1234_5678);
        check("t2_if_not_done", if_done, 1'b0);
        cycle(); lsb_req = 1'b0; #1; check("t2_gap_idle", mem_a, 32'd0);
        check("t2_lsb_pulse", lsb_done, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("t2_if_a%0d", k), mem_a, 32'(k));
        end
        cycle(); check("t2_if_done_early", if_done, 1'b0);
        cycle(); check("t2_if_done", if_done, 1'b1); check("t2_if_data", if_data, 32'h0010_0093);
        if_req = 1'b0;

        // Store half to the IO window with io_buffer_full held for 3 WR cycles
        cycle();
        lsb_req = 1'b1; lsb_type = 1'b1; lsb_width = 2'd1; lsb_addr = 32'h3_0000;
        lsb_wdata = 32'h1234_BEEF; io_buffer_full = 1'b1; #1;
        check("t3_idle_wr", mem_wr, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("t3_stall_wr%0d", k), mem_wr, 1'b0);
        end
        cycle(); io_buffer_full = 1'b0; #1;
        check("t3_wr0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h3_0000, 8'hEF});
        cycle(); check("t3_wr1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h3_0001, 8'hBE});
        cycle(); check("t3_done", {lsb_done, mem_wr}, 2'b10);
        cycle(); lsb_req = 1'b0; #1; check("t3_done_once", {lsb_done, mem_wr}, 2'b00);
        cycle(); check("t3_no_regrant", mem_wr, 1'b0);
        check("t3_ram", {ram[18'h30002], ram[18'h30001], ram[18'h30000]}, 24'h5ABEEF);

        // Flush in the 3rd RD cycle of a fetch; a pending store is then granted
        cycle(); if_req = 1'b1; if_addr = 32'h500; #1;
        cycle(); check("t4_a0", mem_a, 32'h500);
        cycle(); check("t4_a1", mem_a, 32'h501);
        cycle();
        jump_wrong = 1'b1;
        lsb_req = 1'b1; lsb_type = 1'b1; lsb_width = 2'd0; lsb_addr = 32'h600; lsb_wdata = 32'h0000_00A5;
        #1; check("t4_a2", mem_a, 32'h502);
        cycle(); jump_wrong = 1'b0; if_req = 1'b0; #1;
        check("t4_idle", {mem_a, mem_wr, if_done}, 34'd0);
        cycle(); check("t4_store", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h600, 8'hA5});
        cycle(); check("t4_store_done", {lsb_done, if_done}, 2'b10);
        cycle(); lsb_req = 1'b0; #1; check("t4_no_if_done", if_done, 1'b0);
        // Flush in IDLE: fetch and load requests are ignored
        cycle();
        jump_wrong = 1'b1; if_req = 1'b1; if_addr = 32'h500;
        lsb_req = 1'b1; lsb_type = 1'b0; lsb_width = 2'd2; lsb_addr = 32'h200;
        cycle(); jump_wrong = 1'b0; if_req = 1'b0; lsb_req = 1'b0; #1;
        check("t4_flush_idle", mem_a, 32'd0);
        cycle(); check("t4_flush_idle2", mem_a, 32'd0);

        // rdy low for 4 cycles in the middle of a word load
        cycle(); lsb_req = 1'b1; lsb_type = 1'b0; lsb_width = 2'd2; lsb_addr = 32'h700; #1;
        cycle(); check("t5_a0", mem_a, 32'h700);
        cycle(); check("t5_a1", mem_a, 32'h701);
        cycle(); rdy = 1'b0; #1; check("t5_pause0", {mem_a, mem_wr}, {32'h702, 1'b0});
        for (int k = 1; k < 4; k++) begin
            cycle();
            check($sformatf("t5_pause%0d", k), {mem_a, lsb_done}, {32'h702, 1'b0});
        end
        cycle(); rdy = 1'b1; #1; check("t5_resume", mem_a, 32'h702);
        cycle(); check("t5_a3", mem_a, 32'h703);
        cycle(); check("t5_done_early", lsb_done, 1'b0);
        cycle(); check("t5_done", lsb_done, 1'b1); check("t5_rdata", lsb_rdata, 32'h4433_2211);
        cycle(); lsb_req = 1'b0; #1; check("t5_pulse", lsb_done, 1'b0);

        // Continuous LSB byte loads with IF waiting: grant order of the first six accesses
        rst = 1'b1; cycle(); rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h800;
        lsb_req = 1'b1; lsb_type = 1'b0; lsb_width = 2'd0; lsb_addr = 32'h900;
        n_done = 0; order = '0;
        for (int c = 0; c < 200 && n_done < 6; c++) begin
            cycle();
            if (lsb_done) begin
                check($sformatf("t6_rdata%0d", n_done), lsb_rdata, 32'h0000_00C3);
                n_done++;
            end else if (if_done) begin
                check($sformatf("t6_if_data%0d", n_done), if_data, 32'hDEAD_BEEF);
                order[n_done] = 1'b1;
                n_done++;
            end
        end
`ifdef ARB_AGING_EN
        exp_order = 6'b010000;
`else
        exp_order = 6'b000000;
`endif
        check("t6_done_count", 32'(n_done), 32'd6);
        check("t6_order", order, exp_order);
        if_req = 1'b0; lsb_req = 1'b0;
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
